// File: rtl/pulse_divider.sv
// Runtime-programmable clock divider with toggle, strobe and counted-burst output modes.
// Optional feature macro: PULSE_COUNT_EN adds a 16-bit free-running tick counter output.
module pulse_divider #(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 2,
    parameter int BURST       = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] div,
    input  logic             start,
    output logic             signal,
    output logic             tick,
    output logic             busy
`ifdef PULSE_COUNT_EN
    ,
    output logic [15:0]      pulse_count
`endif
);

    typedef enum logic [1:0] {
        MODE_TOGGLE = 2'd0,
        MODE_PULSE  = 2'd1,
        MODE_BURST  = 2'd2,
        MODE_HOLD   = 2'd3
    } mode_e;

    localparam logic [7:0]       BURST_N  = 8'(BURST);
    localparam logic [WIDTH-1:0] DIV_RST  = WIDTH'(DEFAULT_DIV);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] div_act_q, div_act_d;
    mode_e            mode_act_q, mode_act_d;
    logic             signal_q, signal_d;
    logic             tick_q, tick_d;
    logic             busy_q, busy_d;
    logic [7:0]       rem_q, rem_d;

    logic [WIDTH-1:0] div_eff;
    logic             counting;
    logic             terminal;
    logic             start_acc;
    logic             load;
    mode_e            mode_in;

    assign mode_in   = mode_e'(mode);
    assign div_eff   = (div_act_q == '0) ? WIDTH'(1) : div_act_q;
    assign counting  = enable && ((mode_act_q == MODE_TOGGLE) || (mode_act_q == MODE_PULSE) ||
                                  ((mode_act_q == MODE_BURST) && busy_q));
    // div_eff >= 1, so div_eff-1 never underflows and the compare caps the counter below 2^WIDTH-1.
    assign terminal  = counting && (cnt_q == div_eff - WIDTH'(1));
    assign start_acc = enable && (mode_act_q == MODE_BURST) && !busy_q && start;
    assign load      = !enable || terminal || start_acc;

    always_comb begin
        cnt_d      = cnt_q;
        div_act_d  = div_act_q;
        mode_act_d = mode_act_q;
        signal_d   = signal_q;
        tick_d     = 1'b0;
        busy_d     = busy_q;
        rem_d      = rem_q;

        if (counting) begin
            cnt_d  = terminal ? '0 : WIDTH'(cnt_q + WIDTH'(1));
            tick_d = terminal;
        end

        if (enable) begin
            case (mode_act_q)
                MODE_TOGGLE: begin
                    if (terminal) signal_d = ~signal_q;
                end
                MODE_PULSE: begin
                    signal_d = terminal;
                end
                MODE_BURST: begin
                    if (busy_q) begin
                        signal_d = terminal;
                        if (terminal) begin
                            rem_d = rem_q - 8'd1;
                            if (rem_q == 8'd1) busy_d = 1'b0;
                        end
                    end else begin
                        cnt_d    = '0;
                        signal_d = 1'b0;
                        if (start) begin
                            busy_d = 1'b1;
                            rem_d  = BURST_N;
                        end
                    end
                end
                default: begin
                    signal_d = 1'b0;
                    busy_d   = 1'b0;
                end
            endcase
        end

        // Mode switches land only here; any switch restarts the period and drops a running burst.
        if (load) begin
            div_act_d  = div;
            mode_act_d = mode_in;
            if (mode_in != mode_act_q) begin
                cnt_d    = '0;
                busy_d   = 1'b0;
                rem_d    = '0;
                signal_d = (mode_in == MODE_PULSE) ? tick_d : 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q      <= '0;
            div_act_q  <= DIV_RST;
            mode_act_q <= MODE_TOGGLE;
            signal_q   <= 1'b0;
            tick_q     <= 1'b0;
            busy_q     <= 1'b0;
            rem_q      <= '0;
        end else begin
            cnt_q      <= cnt_d;
            div_act_q  <= div_act_d;
            mode_act_q <= mode_act_d;
            signal_q   <= signal_d;
            tick_q     <= tick_d;
            busy_q     <= busy_d;
            rem_q      <= rem_d;
        end
    end

    assign signal = signal_q;
    assign tick   = tick_q;
    assign busy   = busy_q;

`ifdef PULSE_COUNT_EN
    logic [15:0] pcount_q, pcount_d;

    always_comb begin
        pcount_d = pcount_q;
        if (tick_d) pcount_d = pcount_q + 16'd1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) pcount_q <= '0;
        else          pcount_q <= pcount_d;
    end

    assign pulse_count = pcount_q;
`endif

endmodule

// File: doc/pulse_divider.md
Name: pulse_divider

Overview:
- Parametrised successor to the fixed divide-by-4 pulse generator.
- Divides the single system clock by a runtime-programmable ratio.
- Three output modes: square-wave toggle, single-cycle strobe, and counted burst started by a trigger.
- Feeds lab waveform benches and slow-rate enables for downstream counters and FSMs; sits directly after the clock source.

Parameters:
WIDTH, 8, width of divisor and internal period counter
DEFAULT_DIV, 2, divisor in force after reset until first sampling of div
BURST, 4, number of strobes emitted per burst in MODE_BURST (1..255)

Ports:
clock  input  1  system clock, all logic on rising edge
reset_n  input  1  asynchronous active-low reset
enable  input  1  1 = run counter, 0 = freeze counter and hold signal
mode  input  2  0 = TOGGLE, 1 = PULSE, 2 = BURST, 3 = HOLD
div  input  WIDTH  requested divide ratio; 0 is treated as 1
start  input  1  burst trigger, used only in BURST mode
signal  output  1  divided output waveform
tick  output  1  one-cycle strobe at every terminal count
busy  output  1  burst in progress

Behaviour:
- Reset (async assert, sync release): counter=0, div_act=DEFAULT_DIV, mode_act=TOGGLE, signal=0, tick=0, busy=0, remaining=0.
- div_act and mode_act load from div/mode on: any edge with enable=0; the terminal-count edge; the edge accepting start. At all other edges they are stable, so no mid-period glitches.
- div_eff = (div_act==0) ? 1 : div_act.
- Counting edge: enable=1 and (mode_act is TOGGLE or PULSE, or busy=1).
  - Counter increments.
  - When counter==div_eff-1: counter<=0 and tick<=1 (registered; high the cycle after the terminal edge).
- tick is 0 on every other edge.
- TOGGLE: signal toggles on each terminal edge. Period = 2*div_eff clocks, 50% duty. div=2 reproduces the legacy divide-by-4 waveform.
- PULSE: signal mirrors tick, giving a one-clock-high pulse every div_eff clocks.
- BURST:
  - Idle (busy=0): counter held at 0, signal=0, tick=0.
  - start=1 with enable=1 and busy=0: busy<=1, remaining<=BURST, counter<=0.
  - Each terminal edge: tick=1, signal=1 for that cycle, remaining decrements.
  - The terminal edge that takes remaining 1->0 also clears busy. Re-trigger is possible on the very next edge.
  - start while busy=1 is ignored, with no restart and no queueing.
- HOLD: counter frozen, signal=0, tick=0, busy=0.
- enable=0: counter, signal and remaining frozen; tick forced 0. A burst in progress resumes exactly when enable returns.
- Mode change takes effect only at a load point:
  - Switching away from BURST while busy=1 aborts the burst: busy<=0, remaining<=0.
  - Entering TOGGLE from another mode starts with signal=0.
- A div change mid-period is applied only after the current period completes.
- Counter width is WIDTH. div_eff up to 2^WIDTH-1 must not overflow.
- reset_n asserted mid-operation: all state returns to reset values immediately, regardless of clock.

Optional Feature:
PULSE_COUNT_EN:
- Defined: adds output pulse_count (16 bits). It increments on every tick, wraps 0xFFFF->0x0000, and is cleared by reset_n only.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Test Plan:
- Reset, enable=1, mode=0, div=2 held -> signal toggles on every 2nd clock (period 4 clocks); tick high one cycle in each 2 clocks; busy=0.
- mode=1, div=5 -> signal high exactly 1 clock in every 5; 4 pulses observed in 20 clocks; signal==tick.
- mode=2, div=3, BURST=4, one-clock start -> busy for exactly 12 clocks; exactly 4 strobes, 3 clocks apart; second start during busy ignored; restart accepted on the first edge after busy falls.
- mode=0, div=4, change div to 1 mid-period -> current half-period still lasts 4 clocks, then signal toggles every clock; div=0 behaves identically to div=1.
- mode=2 burst running, drop enable for 5 clocks -> no ticks, counter and remaining frozen, burst completes with the full 4 strobes after enable returns.
- Assert reset_n mid-burst between clock edges -> signal, tick and busy go 0 immediately; after release, div_act=DEFAULT_DIV and (with PULSE_COUNT_EN) pulse_count=0.
